// File: rtl/gb_mem_responder.sv
// Game Boy memory-map responder for the SM83 core bus: internal VRAM/WRAM/OAM/HRAM/IE,
// external ROM port, and the $FF46 OAM DMA engine that owns the map while it runs.
module gb_mem_responder #(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] r_addr,
  input  logic [15:0] w_addr,
  input  logic [7:0]  w_data,
  input  logic        w_wen,
  output logic [7:0]  r_data,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        dma_active
);

  typedef enum logic [3:0] {
    RG_ROM, RG_VRAM, RG_ERAM, RG_WRAM, RG_OAM, RG_UNUSED, RG_DMA, RG_IO, RG_HRAM, RG_IE
  } region_e;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_e;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  // Echo space ($E000-$FDFF) lands in RG_WRAM; the low 13 bits already index the alias.
  function automatic region_e decode(input logic [15:0] a);
    region_e rg;
    if (a[15] == 1'b0)          rg = RG_ROM;
    else if (a < 16'hA000)      rg = RG_VRAM;
    else if (a < 16'hC000)      rg = RG_ERAM;
    else if (a < 16'hFE00)      rg = RG_WRAM;
    else if (a < 16'hFEA0)      rg = RG_OAM;
    else if (a < 16'hFF00)      rg = RG_UNUSED;
    else if (a == 16'hFF46)     rg = RG_DMA;
    else if (a < 16'hFF80)      rg = RG_IO;
    else if (a == 16'hFFFF)     rg = RG_IE;
    else                        rg = RG_HRAM;
    return rg;
  endfunction

  logic [7:0] vram [8192];
  logic [7:0] wram [8192];
  logic [7:0] oam  [DMA_LEN];
  logic [7:0] hram [127];

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dma_reg_q, dma_reg_d;
  logic [4:0] ie_q, ie_d;

  region_e    r_region_s, w_region_s;
  logic [15:0] src_s;
  logic [7:0]  dma_byte_s;
  logic        wr_ok_s;
  logic        dma_kick_s;

  assign r_region_s = decode(r_addr);
  assign w_region_s = decode(w_addr);
  assign src_s      = {dma_reg_q, 8'h00} + {8'h00, idx_q};
  assign dma_active = (state_q != IDLE);
  assign rom_addr   = dma_active ? src_s[14:0] : r_addr[14:0];
  assign dma_kick_s = w_wen && (w_addr == 16'hFF46);
  assign wr_ok_s    = w_wen && (!dma_active || (w_region_s == RG_HRAM));

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'h00;
      dma_reg_q <= 8'hFF;
      ie_q      <= 5'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dma_reg_q <= dma_reg_d;
      ie_q      <= ie_d;
    end
  end

  // DMA sequencing and register writes; a $FF46 write overrides any in-flight transfer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dma_reg_d = dma_reg_q;
    ie_d      = ie_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      START: begin
        state_d = XFER;
        idx_d   = 8'h00;
      end
      XFER: begin
        idx_d = idx_q + 8'h01;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: state_d = IDLE;
    endcase
    if (dma_kick_s) begin
      dma_reg_d = w_data;
      idx_d     = 8'h00;
      state_d   = START;
    end else begin
      dma_reg_d = dma_reg_q;
    end
    if (wr_ok_s && (w_region_s == RG_IE)) begin
      ie_d = w_data[4:0];
    end else begin
      ie_d = ie_q;
    end
  end

  // DMA source fetch: $E0-$FF bases fold onto WRAM, never reaching OAM or I/O.
  always_comb begin
    dma_byte_s = 8'hFF;
    if (src_s[15:13] == 3'b111) begin
      dma_byte_s = wram[src_s[12:0]];
    end else begin
      case (decode(src_s))
        RG_ROM:  dma_byte_s = rom_data;
        RG_VRAM: dma_byte_s = vram[src_s[12:0]];
        RG_WRAM: dma_byte_s = wram[src_s[12:0]];
        default: dma_byte_s = 8'hFF;
      endcase
    end
  end

  // Core read mux; only HRAM stays visible while DMA owns the bus.
  always_comb begin
    r_data = 8'hFF;
    if (dma_active && (r_region_s != RG_HRAM)) begin
      r_data = 8'hFF;
    end else begin
      case (r_region_s)
        RG_ROM:    r_data = rom_data;
        RG_VRAM:   r_data = vram[r_addr[12:0]];
        RG_ERAM:   r_data = 8'hFF;
        RG_WRAM:   r_data = wram[r_addr[12:0]];
        RG_OAM:    r_data = oam[r_addr[7:0]];
        RG_UNUSED: r_data = 8'h00;
        RG_DMA:    r_data = dma_reg_q;
        RG_IO:     r_data = 8'hFF;
        RG_HRAM:   r_data = hram[r_addr[6:0]];
        RG_IE:     r_data = {3'b111, ie_q};
        default:   r_data = 8'hFF;
      endcase
    end
  end

  // Memory arrays (not reset); core writes and DMA copies never target the same array.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      case (w_region_s)
        RG_VRAM: vram[w_addr[12:0]] <= w_data;
        RG_WRAM: wram[w_addr[12:0]] <= w_data;
        RG_OAM:  oam[w_addr[7:0]]   <= w_data;
        RG_HRAM: hram[w_addr[6:0]]  <= w_data;
        default: ;
      endcase
    end
    if (!rst && (state_q == XFER)) begin
      oam[idx_q] <= dma_byte_s;
    end
  end

endmodule

// File: tb/tb_gb_mem_responder.sv
// Directed self-checking bench for gb_mem_responder: map decode, echo, DMA timing/copy,
// restart, core blocking during DMA and asynchronous reset abort.
module tb_gb_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] r_addr;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic        w_wen;
  logic [7:0]  r_data;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        dma_active;

  int n_cmp;
  int n_err;

  gb_mem_responder #(.DMA_LEN(160)) dut (
    .clk        (clk),
    .rst        (rst),
    .r_addr     (r_addr),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_wen      (w_wen),
    .r_data     (r_data),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .dma_active (dma_active)
  );

  // ROM model: returns the low address byte.
  assign rom_data = rom_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    w_addr = a;
    w_data = d;
    w_wen  = 1'b1;
    @(negedge clk);
    w_wen  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    r_addr = a;
    #1;
    d = r_data;
  endtask

  initial begin
    logic [7:0] d;
    int cnt;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    w_wen  = 1'b0;
    w_addr = 16'h0000;
    w_data = 8'h00;
    r_addr = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("rst_dma_active", {15'h0, dma_active}, 16'h0000);
    rd(16'hFF46, d); check_val("rst_dma_reg", {8'h0, d}, 16'h00FF);
    rst = 1'b0;
    @(negedge clk);

    // Map defaults
    rd(16'hA000, d); check_val("eram_rd", {8'h0, d}, 16'h00FF);
    rd(16'hFEA0, d); check_val("unused_rd", {8'h0, d}, 16'h0000);
    rd(16'hFF10, d); check_val("io_rd", {8'h0, d}, 16'h00FF);
    rd(16'hFF46, d); check_val("dmareg_rd", {8'h0, d}, 16'h00FF);
    rd(16'hFFFF, d); check_val("ie_rst", {8'h0, d}, 16'h00E0);
    rd(16'h0123, d); check_val("rom_rd", {8'h0, d}, 16'h0023);
    check_val("rom_addr_idle", {1'b0, rom_addr}, 16'h0123);
    wr(16'hFFFF, 8'hFF);
    rd(16'hFFFF, d); check_val("ie_wr", {8'h0, d}, 16'h00FF);
    wr(16'h0123, 8'h99);
    rd(16'h0123, d); check_val("rom_wr_ignored", {8'h0, d}, 16'h0023);

    // WRAM / echo / VRAM / HRAM
    wr(16'hC123, 8'h5A);
    rd(16'hE123, d); check_val("echo_rd", {8'h0, d}, 16'h005A);
    wr(16'hFDFF, 8'hA5);
    rd(16'hDDFF, d); check_val("echo_wr", {8'h0, d}, 16'h00A5);
    wr(16'h8123, 8'h9C);
    rd(16'h8123, d); check_val("vram_rw", {8'h0, d}, 16'h009C);
    wr(16'hFF80, 8'h42);
    rd(16'hFF80, d); check_val("hram_rw", {8'h0, d}, 16'h0042);

    // DMA copy from WRAM
    for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), 8'(i) ^ 8'h3C);
    for (int i = 0; i < 160; i++) wr(16'hC100 + 16'(i), 8'(i) ^ 8'hA5);
    wr(16'hFF46, 8'hC0);
    cnt = 0;
    while (dma_active && cnt < 400) begin
      cnt++;
      if (cnt == 5) begin
        rd(16'hC000, d); check_val("dma_block_rd", {8'h0, d}, 16'h00FF);
        rd(16'hFF80, d); check_val("dma_hram_rd", {8'h0, d}, 16'h0042);
      end
      @(negedge clk);
    end
    check_val("dma_len_c0", 16'(cnt), 16'd161);
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), d); check_val("oam_c0", {8'h0, d}, {8'h0, 8'(i) ^ 8'h3C});
    end

    // DMA from ROM with concurrent blocked / HRAM writes
    wr(16'hFF46, 8'h12);
    cnt = 0;
    while (dma_active && cnt < 400) begin
      cnt++;
      if (cnt >= 2 && cnt <= 161) check_val("rom_addr_xfer", {1'b0, rom_addr}, 16'h1200 + 16'(cnt - 2));
      if (cnt == 10) begin w_addr = 16'hC000; w_data = 8'h77; w_wen = 1'b1; end
      if (cnt == 11) begin w_addr = 16'hFF90; end
      if (cnt == 12) begin w_wen = 1'b0; end
      @(negedge clk);
    end
    check_val("dma_len_rom", 16'(cnt), 16'd161);
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), d); check_val("oam_rom", {8'h0, d}, 16'(i));
    end
    rd(16'hC000, d); check_val("blocked_wram_wr", {8'h0, d}, 16'h003C);
    rd(16'hFF90, d); check_val("hram_wr_in_dma", {8'h0, d}, 16'h0077);

    // Restart at idx = 50
    wr(16'hFF46, 8'hC0);
    repeat (51) @(negedge clk);
    w_addr = 16'hFF46; w_data = 8'hC1; w_wen = 1'b1;
    @(negedge clk);
    w_wen = 1'b0;
    cnt = 0;
    while (dma_active && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check_val("dma_len_restart", 16'(cnt), 16'd161);
    rd(16'hFF46, d); check_val("dmareg_restart", {8'h0, d}, 16'h00C1);
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), d); check_val("oam_restart", {8'h0, d}, {8'h0, 8'(i) ^ 8'hA5});
    end

    // Reset mid-XFER
    wr(16'hFF46, 8'hC0);
    repeat (29) @(negedge clk);
    check_val("pre_rst_active", {15'h0, dma_active}, 16'h0001);
    rst = 1'b1;
    #1;
    check_val("rst_abort", {15'h0, dma_active}, 16'h0000);
    rd(16'hFF46, d); check_val("rst_dma_reg_mid", {8'h0, d}, 16'h00FF);
    rd(16'hFFFF, d); check_val("rst_ie_mid", {8'h0, d}, 16'h00E0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("post_rst_idle", {15'h0, dma_active}, 16'h0000);
    rd(16'hFE00, d); check_val("oam_partial_lo", {8'h0, d}, 16'h003C);
    rd(16'hFE64, d); check_val("oam_partial_hi", {8'h0, d}, {8'h0, 8'd100 ^ 8'hA5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gb_mem_responder.md
# gb_mem_responder

Responder end of the SM83 core memory bus: decodes every core read and write against the Game Boy memory map and answers from internal VRAM, WRAM, OAM, HRAM and the IE register, or from an external cartridge ROM port. Reads are combinational within the core's M-cycle. Writes commit on the clock edge. It also contains the OAM DMA engine at $FF46, which takes over the map for 161 cycles and restricts the core to HRAM while active.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes copied per OAM DMA.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `r_addr`  in  16: core read address.
- `w_addr`  in  16: core write address.
- `w_data`  in  8: core write data.
- `w_wen`  in  1: core write enable; the write commits on the rising edge.
- `r_data`  out  8: read data for `r_addr`; combinational.
- `rom_addr`  out  15: external ROM address ($0000-$7FFF).
- `rom_data`  in  8: external ROM data; combinational response to `rom_addr`.
- `dma_active`  out  1: OAM DMA in progress, including the startup cycle.

## Operation
Memory map, read side and write side:
- **$0000-$7FFF (ROM):** read returns `rom_data`; writes are ignored.
- **$8000-$9FFF (VRAM):** 8 KiB, read/write.
- **$A000-$BFFF (ext RAM):** read returns $FF; writes are ignored.
- **$C000-$DFFF (WRAM):** 8 KiB, read/write.
- **$E000-$FDFF (echo):** aliases WRAM at address & $DFFF, read and write.
- **$FE00-$FE9F (OAM):** 160 B, read/write.
- **$FEA0-$FEFF:** read returns $00; writes are ignored.
- **$FF46 (DMA register):** read returns the last value written. A write starts or restarts DMA.
- **Other $FF00-$FF7F:** read returns $FF; writes are ignored.
- **$FF80-$FFFE (HRAM):** 127 B, read/write.
- **$FFFF (IE):** holds bits [4:0]; read returns {3'b111, ie[4:0]}.

When DMA is not active, `rom_addr` is `r_addr[14:0]`.

DMA state machine:
- States: IDLE, START, XFER.
- **IDLE -> START:** on an edge where `w_wen` is high and `w_addr` = $FF46. `dma_reg` <= `w_data`; `idx` <= 0.
- **START -> XFER:** after one cycle. No copy happens in START.
- **XFER, each edge:** OAM[idx] <= byte at `src` = {`dma_reg`, 8'h00} + idx; then idx <= idx + 1.
- **XFER -> IDLE:** on the edge that copies idx = `DMA_LEN` - 1.
- Source decode uses the same map as the core. Bases $E0-$FF fold to WRAM via & $DFFF. Base $FE/$FF sources read WRAM $DE00/$DF00, not OAM/IO.
- While `dma_active`, `rom_addr` = `src[14:0]`.
- **Core access during DMA:** core reads anywhere except HRAM return $FF. Core writes anywhere except HRAM and $FF46 are ignored. IE is also blocked.
- **Restart:** a $FF46 write during START or XFER loads the new `dma_reg`, sets idx <= 0, and enters START. OAM bytes already copied are left as they are.
- **Simultaneous events:** a core write to HRAM in the same cycle as a DMA copy both commit, because the two target disjoint memories.
- **Width:** `idx` is 8 bits. `src` is a 16-bit sum; no carry out of the low byte occurs for `DMA_LEN` <= 256.

## Timing
Reset values while `rst` is asserted:
- `dma_active` = 0; state = IDLE; `idx` = 0.
- `dma_reg` = $FF; IE = $00.
- `r_data` follows the map with the reset register values. RAM arrays are not reset and their contents are undefined.
- Reset asserted mid-DMA aborts immediately; OAM keeps its partial contents.

Read and write latency:
- Read latency is 0 cycles: `r_data` is valid in the same cycle as `r_addr`, and the core samples it on the next edge.
- Write latency is 1 edge: a read of the same address in the following cycle returns the new value.

DMA cycle count, with edge E0 being the $FF46 write:
- `dma_active` rises after E0.
- START occupies the cycle between E0 and E1.
- Bytes 0..159 are written at edges E2..E161.
- `dma_active` falls after E161, so it is high for 161 cycles in total.

## Test plan
- **WRAM/echo:** write $5A at $C123, then read $E123 -> $5A. Write $A5 at $FDFF, then read $DDFF -> $A5.
- **Map defaults:** after reset, reads of $A000 -> $FF, $FEA0 -> $00, $FF10 -> $FF, $FF46 -> $FF, $FFFF -> $E0. Write $FF to $FFFF, then read -> $FF.
- **DMA copy:** fill $C000-$C09F with i^$3C, write $C0 to $FF46.
  - `dma_active` is high for exactly 161 cycles.
  - OAM[i] = i^$3C afterwards.
  - During DMA, a read of $C000 -> $FF and a read of $FF80 -> its HRAM value.
- **DMA from ROM:** ROM model returns low address byte; write $12 to $FF46.
  - `rom_addr` steps $1200..$129F during XFER.
  - OAM[i] = i afterwards.
- **Restart:** write $C0 to $FF46, then write $C1 to $FF46 at the edge where `idx` = 50.
  - `dma_active` stays high for 161 cycles counted from the second write.
  - Final OAM = $C100-$C19F contents.
- **Blocking/reset:** during DMA, a write of $77 to $C000 is ignored and a write of $77 to $FF90 persists. Asserting `rst` mid-XFER drops `dma_active` the same cycle, and `dma_reg` reads $FF.
